// File: rtl/nibbler_pkg.sv
// Shared definitions for the nibbler fetch unit: pc width, jump opcodes and
// the helpers that classify and resolve conditional jumps.
package nibbler_pkg;

  localparam int PC_W   = 12;
  localparam int OP_W   = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_JC  = 4'h0,
    OP_JNC = 4'h1,
    OP_JZ  = 4'h2,
    OP_JNZ = 4'h3,
    OP_JMP = 4'h4
  } opcode_e;

  function automatic logic is_jump(input logic [OP_W-1:0] op);
    return (op <= OP_JMP);
  endfunction

  // Non-jump opcodes resolve as not taken so callers need not pre-filter.
  function automatic logic jump_cond(input logic [OP_W-1:0] op,
                                     input logic c, input logic z);
    logic t;
    t = 1'b0;
    case (op)
      OP_JC:   t = c;
      OP_JNC:  t = ~c;
      OP_JZ:   t = z;
      OP_JNZ:  t = ~z;
      OP_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ROM bus, phase/flag inputs and fetch-unit status outputs in one bundle.
interface instr_fetch_if;
  import nibbler_pkg::*;

  logic              phase_in;
  logic [BYTE_W-1:0] rom_data;
  logic              c_flag;
  logic              z_flag;
  logic [PC_W-1:0]   rom_addr;
  logic [BYTE_W-1:0] instr;
  logic              exec_valid;
  logic              jump_taken;
  logic              phase_err;

  modport master (
    input  phase_in, rom_data, c_flag, z_flag,
    output rom_addr, instr, exec_valid, jump_taken, phase_err
  );

  modport slave (
    output phase_in, rom_data, c_flag, z_flag,
    input  rom_addr, instr, exec_valid, jump_taken, phase_err
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// 12-bit program counter: load has priority over increment, otherwise hold.
module pc_reg
  import nibbler_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // Increment wraps modulo 2^PC_W with no carry out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-phase instruction fetch/sequencer: fetch loads the IR, execute either
// resolves a two-byte jump or hands the instruction to the datapath.
module instr_fetch
  import nibbler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  logic              exp_phase;
  logic              ir_valid;
  logic              jump_taken_q;
  logic              phase_err_q;
  logic [BYTE_W-1:0] instr_q;
  logic [PC_W-1:0]   pc;

  logic              fetch;
  logic              execute;
  logic              op_jump;
  logic              taken;
  logic              pc_load;
  logic              pc_inc;
  logic [PC_W-1:0]   jump_target;

  // The cycle is handled as phase_in says, even when it disagrees with exp_phase.
  assign fetch       = ~bus.phase_in;
  assign execute     = bus.phase_in & ir_valid;
  assign op_jump     = is_jump(instr_q[7:4]);
  assign taken       = execute & op_jump &
                       jump_cond(instr_q[7:4], bus.c_flag, bus.z_flag);
  assign jump_target = {instr_q[3:0], bus.rom_data};

  // A not-taken jump still consumes its second byte.
  assign pc_load = taken;
  assign pc_inc  = fetch | (execute & op_jump & ~taken);

  pc_reg u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jump_target),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_phase    <= 1'b0;
      ir_valid     <= 1'b0;
      instr_q      <= '0;
      jump_taken_q <= 1'b0;
      phase_err_q  <= 1'b0;
    end else begin
      // Toggle when in step; resync to the observed phase otherwise.
      exp_phase    <= ~bus.phase_in;
      jump_taken_q <= taken;
      if (bus.phase_in != exp_phase) phase_err_q <= 1'b1;
      if (fetch) begin
        instr_q  <= bus.rom_data;
        ir_valid <= 1'b1;
      end
    end
  end

  assign bus.rom_addr   = pc;
  assign bus.instr      = instr_q;
  assign bus.exec_valid = ~reset & execute & ~op_jump;
  assign bus.jump_taken = jump_taken_q;
  assign bus.phase_err  = phase_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch: each step queues the values
// expected during that cycle; a negedge monitor pops and compares.
module tb_instr_fetch;
  import nibbler_pkg::*;

  logic clk;
  logic reset;
  logic [7:0] rom [4096];

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  typedef struct {
    int         step;
    logic [11:0] pc;
    logic [7:0]  instr;
    logic        ev;
    logic        jt;
    logic        perr;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int stp, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, stp, act, want);
  endtask

  // Inputs for one cycle, then the outputs expected before that cycle's edge.
  task automatic step(input logic r, input logic ph, input logic c, input logic z,
                      input logic [11:0] e_pc, input logic [7:0] e_instr,
                      input logic e_ev, input logic e_jt, input logic e_perr);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = r;
    bus.phase_in = ph;
    bus.c_flag   = c;
    bus.z_flag   = z;
    step_no++;
    e.step  = step_no;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.ev    = e_ev;
    e.jt    = e_jt;
    e.perr  = e_perr;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",         e.step, int'(bus.rom_addr),   int'(e.pc));
        chk("instr",      e.step, int'(bus.instr),      int'(e.instr));
        chk("exec_valid", e.step, int'(bus.exec_valid), int'(e.ev));
        chk("jump_taken", e.step, int'(bus.jump_taken), int'(e.jt));
        chk("phase_err",  e.step, int'(bus.phase_err),  int'(e.perr));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.phase_in = 1'b0;
    bus.c_flag   = 1'b0;
    bus.z_flag   = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    rom[0] = 8'h5A;

    // Non-jump fetch/execute
    step(1, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 12'h001, 8'h5A, 1, 0, 0);
    step(0, 0, 0, 0, 12'h001, 8'h5A, 0, 0, 0);

    // JMP 0x321
    step(1, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    rom[0] = 8'h43; rom[1] = 8'h21;
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 12'h001, 8'h43, 0, 0, 0);
    step(0, 0, 0, 0, 12'h321, 8'h43, 0, 1, 0);
    step(0, 1, 0, 0, 12'h322, 8'hF0, 1, 0, 0);

    // JC 0x080 not taken (carry raised only in the following fetch)
    step(1, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    rom[0] = 8'h00; rom[1] = 8'h80;
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 12'h001, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 12'h002, 8'h00, 0, 0, 0);
    step(0, 1, 1, 0, 12'h003, 8'hF0, 1, 0, 0);

    // JC 0x080 taken
    step(1, 0, 1, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 0, 1, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 1, 0, 12'h001, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 12'h080, 8'h00, 0, 1, 0);
    step(0, 1, 0, 0, 12'h081, 8'hF0, 1, 0, 0);

    // JZ 0x765 taken, then JNZ 0xABC not taken
    step(1, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    rom[0] = 8'h27; rom[1] = 8'h65;
    rom[12'h765] = 8'h3A; rom[12'h766] = 8'hBC;
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 0, 1, 12'h001, 8'h27, 0, 0, 0);
    step(0, 0, 0, 0, 12'h765, 8'h27, 0, 1, 0);
    step(0, 1, 0, 1, 12'h766, 8'h3A, 0, 0, 0);
    step(0, 0, 0, 0, 12'h767, 8'h3A, 0, 0, 0);
    step(0, 1, 0, 0, 12'h768, 8'hF0, 1, 0, 0);

    // JMP 0xFFF, then fetch there wraps pc to 0x000
    step(1, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    rom[0] = 8'h4F; rom[1] = 8'hFF; rom[12'hFFF] = 8'h77;
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 12'h001, 8'h4F, 0, 0, 0);
    step(0, 0, 0, 0, 12'hFFF, 8'h4F, 0, 1, 0);
    step(0, 1, 0, 0, 12'h000, 8'h77, 1, 0, 0);

    // Two fetches in a row: sticky phase error, second fetch still processed
    step(0, 0, 0, 0, 12'h000, 8'h77, 0, 0, 0);
    step(0, 0, 0, 0, 12'h001, 8'h4F, 0, 0, 0);
    step(0, 1, 0, 0, 12'h002, 8'hFF, 1, 0, 1);
    step(0, 0, 0, 0, 12'h002, 8'hFF, 0, 0, 1);
    step(0, 1, 0, 0, 12'h003, 8'hF0, 1, 0, 1);
    step(1, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);

    // Reset during a JMP execute discards the jump
    rom[0] = 8'h43; rom[1] = 8'h21;
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(1, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0);
    step(0, 1, 0, 0, 12'h001, 8'h43, 0, 0, 0);
    step(0, 0, 0, 0, 12'h321, 8'h43, 0, 1, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
